psum_drain_unit: RTL and testbench

Column-output collector for the weight-stationary systolic array. It sits below the last PE of a column and consumes that PE's `partial_sum_out` stream, counting results per tile. Each accumulator word is requantized (round, shift, saturate) back to activation width, then buffered in a small FIFO. Results are presented on a valid/ready stream toward the activation buffer or host, with a tile-last marker and a completion pulse.

---
 rtl/psum_drain_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_psum_drain_unit.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain_unit.sv
`default_nettype none
// ============================================================================
// Module   : psum_drain_unit
// Purpose  : Column-output collector for the weight-stationary systolic array.
//            It captures TILE_LEN partial sums from the last PE of a column.
//            Each result is rounded, arithmetically shifted and saturated back
//            to DATA_WIDTH, staged, buffered in a FIFO, and then presented on a
//            valid/ready stream with a tile-last marker and a completion pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : begin a tile (honoured only in IDLE)
//   shift_amt  : requant right shift, latched on an accepted start
//   psum_in    : signed partial sum, ACC_WIDTH bits
//   psum_valid : psum_in carries a finished result this cycle
//   out_data   : requantized result, DATA_WIDTH bits
//   out_last   : marks the TILE_LEN-th result of the tile
//   out_valid  : out_data/out_last are valid
//   out_ready  : consumer accepts the word
//   busy       : state is not IDLE
//   tile_done  : one-cycle pulse once the tile has fully drained
//   overflow   : sticky, a result was dropped because the FIFO was full
//   fill_level : current FIFO occupancy
// Build option
//   PSUM_DRAIN_RELU_EN : when defined, negative requant results become 0
// ============================================================================
module psum_drain_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TILE_LEN   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [3:0]                    shift_amt,
    input  logic [ACC_WIDTH-1:0]          psum_in,
    input  logic                          psum_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          tile_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(TILE_LEN + 1);
    localparam int c_EXT_W = ACC_WIDTH + 1;
    localparam logic [c_CNT_W-1:0]        c_LAST_IDX = c_CNT_W'(TILE_LEN - 1);
    localparam logic [c_PTR_W:0]          c_FULL_LVL = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic signed [c_EXT_W-1:0] c_SAT_MAX  = c_EXT_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [c_EXT_W-1:0] c_SAT_MIN  = ~c_SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [3:0]                  r_shift;
    logic                        r_overflow;
    logic                        r_stg_valid;
    logic                        r_stg_last;
    logic [DATA_WIDTH-1:0]       r_stg_data;
    logic [DATA_WIDTH:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]          r_wr_ptr;
    logic [c_PTR_W-1:0]          r_rd_ptr;
    logic [c_PTR_W:0]            r_count;

    logic                        w_start_acc;
    logic                        w_cap;
    logic                        w_full;
    logic                        w_rd;
    logic                        w_wr;
    logic                        w_drop;
    logic [DATA_WIDTH:0]         w_rd_word;
    logic signed [c_EXT_W-1:0]   w_ext;
    logic signed [c_EXT_W-1:0]   w_rnd;
    logic signed [c_EXT_W-1:0]   w_sum;
    logic signed [c_EXT_W-1:0]   w_shf;
    logic [DATA_WIDTH-1:0]       w_q;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_cap       = (r_state == S_COLLECT) && psum_valid;
    assign w_full      = (r_count == c_FULL_LVL);
    assign w_rd        = out_valid && out_ready;
    // A full FIFO still takes the staged word when a read frees a slot on the same edge.
    assign w_wr        = r_stg_valid && (!w_full || w_rd);
    assign w_drop      = r_stg_valid && w_full && !w_rd;

    // Requantization: round half-up, arithmetic shift, saturate.
    always_comb begin
        w_ext = {psum_in[ACC_WIDTH-1], psum_in};
        w_rnd = '0;
        if (r_shift != 4'd0) begin
            w_rnd = c_EXT_W'(1) << (r_shift - 4'd1);
        end
        w_sum = w_ext + w_rnd;
        // Shifting out every magnitude bit leaves only the sign; rounding is skipped.
        if (int'(r_shift) >= ACC_WIDTH) begin
            w_shf = w_ext[c_EXT_W-1] ? '1 : '0;
        end else begin
            w_shf = w_sum >>> r_shift;
        end
        if (w_shf > c_SAT_MAX) begin
            w_q = c_SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shf < c_SAT_MIN) begin
            w_q = c_SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            w_q = w_shf[DATA_WIDTH-1:0];
        end
`ifdef PSUM_DRAIN_RELU_EN
        if (w_q[DATA_WIDTH-1]) begin
            w_q = '0;
        end
`else
`endif
    end

    // Next-state logic; tile_done is the FLUSH -> IDLE transition itself.
    always_comb begin
        w_state_nxt = r_state;
        tile_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (psum_valid && (r_cnt == c_LAST_IDX)) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if ((r_count == '0) && !r_stg_valid) begin
                    w_state_nxt = S_IDLE;
                    tile_done   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_shift     <= 4'd0;
            r_overflow  <= 1'b0;
            r_stg_valid <= 1'b0;
            r_stg_last  <= 1'b0;
            r_stg_data  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_start_acc) begin
                r_cnt   <= '0;
                r_shift <= shift_amt;
            end else if (w_cap) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (w_start_acc) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end

            r_stg_valid <= w_cap;
            if (w_cap) begin
                r_stg_data <= w_q;
                r_stg_last <= (r_cnt == c_LAST_IDX);
            end

            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + (c_PTR_W + 1)'(1);
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - (c_PTR_W + 1)'(1);
            end
        end
    end

    // Storage array carries no reset; the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_stg_last, r_stg_data};
        end
    end

    assign w_rd_word  = r_mem[r_rd_ptr];
    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? w_rd_word[DATA_WIDTH-1:0] : '0;
    assign out_last   = out_valid && w_rd_word[DATA_WIDTH];
    assign busy       = (r_state != S_IDLE);
    assign overflow   = r_overflow;
    assign fill_level = r_count;

endmodule
`default_nettype wire

// File: tb/tb_psum_drain_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_drain_unit
// Purpose  : Self-checking bench for psum_drain_unit (default parameters).
//            Expected words are queued as stimulus is driven and compared as
//            the DUT hands them over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_drain_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  shift_amt;
    logic [15:0] psum_in;
    logic        psum_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        tile_done;
    logic        overflow;
    logic [3:0]  fill_level;

    int          n_vec;
    int          n_err;
    logic [8:0]  sb [$];

    psum_drain_unit #(
        .DATA_WIDTH (8),
        .ACC_WIDTH  (16),
        .FIFO_DEPTH (8),
        .TILE_LEN   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .shift_amt  (shift_amt),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .tile_done  (tile_done),
        .overflow   (overflow),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    // Reference requantizer in plain integer arithmetic.
    function automatic logic [7:0] model_rq(input logic [15:0] p, input int s);
        int v;
        int r;
        v = int'($signed(p));
        if (s >= 16) begin
            r = (v < 0) ? -1 : 0;
        end else begin
            if (s > 0) v = v + (1 << (s - 1));
            r = v >>> s;
        end
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
`ifdef PSUM_DRAIN_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[7:0];
    endfunction

    // Drives one cycle of stimulus and samples the outputs mid-cycle.
    task automatic stream_cycle(input logic v, input logic [15:0] p, input logic r,
                                output logic hs, output logic [8:0] word,
                                output logic done, output logic ov, output logic [3:0] fl);
        psum_valid = v;
        psum_in    = p;
        out_ready  = r;
        @(negedge clk);
        hs   = out_valid && out_ready;
        word = {out_last, out_data};
        done = tile_done;
        ov   = out_valid;
        fl   = fill_level;
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({out_data, out_last, out_valid, busy, tile_done, overflow, fill_level} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_held: got data=%h last=%b valid=%b busy=%b done=%b ovf=%b fill=%0d, required all 0",
                     out_data, out_last, out_valid, busy, tile_done, overflow, fill_level);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_valid, busy, tile_done, overflow, fill_level} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_released_idle: got valid=%b busy=%b done=%b ovf=%b fill=%0d, required all 0",
                     out_valid, busy, tile_done, overflow, fill_level);
        end
    endtask

    // One complete tile. mode 0: out_ready held high (also checks latency,
    // throughput and steady fill level). mode 1: out_ready toggles, start is
    // held high mid-tile, and shift_amt is changed after it was latched.
    task automatic test_tile(input string name, input logic [3:0] s,
                             input logic [15:0] v [16], input logic [7:0] e [16], input int mode);
        logic        hs, done, ov, stall;
        logic [8:0]  word, exp, held;
        logic [3:0]  fl;
        logic [15:0] p;
        int hs_cnt, done_cnt, done_cyc, last_cyc, first_hs, last_hs;
        hs_cnt = 0; done_cnt = 0; done_cyc = -100; last_cyc = -100;
        first_hs = -1; last_hs = -1; stall = 1'b0; held = '0;
        sb.delete();
        start = 1'b1;
        shift_amt = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_after_start: got %b, required 1", name, busy);
        end
        for (int i = 0; i < 16; i++) sb.push_back({(i == 15), e[i]});
        for (int c = 0; c < 80; c++) begin
            p = (c < 16) ? v[c] : 16'h0000;
            start = (mode == 1) && (c < 16);
            if (mode == 1) shift_amt = ~s;
            stream_cycle(c < 16, p, (mode == 0) || (c % 2 == 0), hs, word, done, ov, fl);
            if (stall) begin
                n_vec++;
                if (word !== held) begin
                    n_err++;
                    $display("FAIL %s hold_while_stalled: got %h, required %h", name, word, held);
                end
            end
            stall = ov && !hs;
            held  = word;
            if (hs) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_word: got %h, required no word", name, word);
                end else begin
                    exp = sb.pop_front();
                    if (word !== exp) begin
                        n_err++;
                        $display("FAIL %s word%0d: got last=%b data=%h, required last=%b data=%h",
                                 name, hs_cnt, word[8], word[7:0], exp[8], exp[7:0]);
                    end
                end
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                hs_cnt++;
                if (word[8]) last_cyc = c;
            end
            if (mode == 0 && c == 1) begin
                n_vec++;
                if (ov !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s latency_early_valid: got out_valid=%b, required 0", name, ov);
                end
            end
            if (mode == 0 && c >= 2 && c <= 16) begin
                n_vec++;
                if (fl !== 4'd1) begin
                    n_err++;
                    $display("FAIL %s steady_fill c%0d: got %0d, required 1", name, c, fl);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (done_cnt > 0 && c == done_cyc + 1) break;
        end
        start = 1'b0;
        out_ready = 1'b0;
        n_vec++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL %s tile_done_count: got %0d, required 1", name, done_cnt);
        end
        n_vec++;
        if (done_cyc !== last_cyc + 1) begin
            n_err++;
            $display("FAIL %s tile_done_timing: got cycle %0d, required %0d", name, done_cyc, last_cyc + 1);
        end
        n_vec++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL %s words_missing: got %0d outstanding, required 0", name, sb.size());
        end
        n_vec++;
        if ({busy, overflow} !== 2'b00) begin
            n_err++;
            $display("FAIL %s end_state: got busy=%b ovf=%b, required 0 0", name, busy, overflow);
        end
        if (mode == 0) begin
            n_vec++;
            if (first_hs !== 2 || last_hs - first_hs !== 15 || hs_cnt !== 16) begin
                n_err++;
                $display("FAIL %s throughput: got first=%0d last=%0d count=%0d, required 2 17 16",
                         name, first_hs, last_hs, hs_cnt);
            end
        end
    endtask

    task automatic test_rounding;
        logic [15:0] v [16];
        logic [7:0]  e [16];
        for (int i = 0; i < 16; i++) begin
            v[i] = 16'($urandom);
            e[i] = model_rq(v[i], 4);
        end
        v[0] = 16'h0128;
        e[0] = 8'h13;
        test_tile("rounding", 4'd4, v, e, 0);
    endtask

    task automatic test_saturation;
        logic [15:0] v [16];
        logic [7:0]  e [16];
        for (int i = 0; i < 16; i++) begin
            v[i] = 16'($urandom_range(0, 255)) - 16'd128;
            e[i] = model_rq(v[i], 0);
        end
        v[0] = 16'h7FFF; e[0] = 8'h7F;
        v[1] = 16'h8000; e[1] = 8'h80;
        v[2] = 16'h0080; e[2] = 8'h7F;
        v[3] = 16'hFF7F; e[3] = 8'h80;
`ifdef PSUM_DRAIN_RELU_EN
        e[1] = 8'h00;
        e[3] = 8'h00;
`endif
        test_tile("saturation", 4'd0, v, e, 0);
    endtask

    task automatic test_negative;
        logic [15:0] v [16];
        logic [7:0]  e [16];
        for (int i = 0; i < 16; i++) begin
            v[i] = 16'($urandom);
            e[i] = model_rq(v[i], 4);
        end
        v[0] = 16'hFFE8;
`ifdef PSUM_DRAIN_RELU_EN
        e[0] = 8'h00;
`else
        e[0] = 8'hFF;
`endif
        test_tile("negative", 4'd4, v, e, 0);
    endtask

    task automatic test_full_tile;
        logic [15:0] v [16];
        logic [7:0]  e [16];
        int s;
        s = int'($urandom_range(1, 15));
        for (int i = 0; i < 16; i++) begin
            v[i] = 16'($urandom);
            e[i] = model_rq(v[i], s);
        end
        test_tile("full_tile", 4'(s), v, e, 1);
    endtask

    task automatic test_back_to_back;
        logic [15:0] v [16];
        logic [7:0]  e [16];
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 16; i++) begin
                v[i] = 16'($urandom);
                e[i] = model_rq(v[i], 6 + t);
            end
            test_tile("back_to_back", 4'(6 + t), v, e, 0);
        end
    endtask

    task automatic test_overflow;
        logic        hs, done, ov;
        logic [8:0]  word, exp;
        logic [3:0]  fl;
        int hs_cnt, done_cnt, done_cyc, last_hs;
        hs_cnt = 0; done_cnt = 0; done_cyc = -100; last_hs = -100;
        sb.delete();
        start = 1'b1;
        shift_amt = 4'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i <= 8) sb.push_back({1'b0, 8'(i * 3)});
            stream_cycle(1'b1, 16'(i * 3), 1'b0, hs, word, done, ov, fl);
            if (i == 10) begin
                n_vec++;
                if ({fill_level, overflow, busy, tile_done} !== {4'd8, 1'b1, 1'b1, 1'b0}) begin
                    n_err++;
                    $display("FAIL overflow_after_10: got fill=%0d ovf=%b busy=%b done=%b, required 8 1 1 0",
                             fill_level, overflow, busy, tile_done);
                end
            end
        end
        // Let the final staged word meet a full FIFO with no read.
        stream_cycle(1'b0, 16'h0000, 1'b0, hs, word, done, ov, fl);
        for (int c = 0; c < 40; c++) begin
            stream_cycle(1'b0, 16'h0000, 1'b1, hs, word, done, ov, fl);
            if (hs) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL overflow extra_word: got %h, required no word", word);
                end else begin
                    exp = sb.pop_front();
                    if (word !== exp) begin
                        n_err++;
                        $display("FAIL overflow word%0d: got %h, required %h", hs_cnt, word, exp);
                    end
                end
                hs_cnt++;
                last_hs = c;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (done_cnt > 0 && c == done_cyc + 1) break;
        end
        out_ready = 1'b0;
        n_vec++;
        if (hs_cnt !== 8 || done_cnt !== 1 || done_cyc !== last_hs + 1) begin
            n_err++;
            $display("FAIL overflow_drain: got words=%0d done_pulses=%0d done_cyc=%0d, required 8 1 %0d",
                     hs_cnt, done_cnt, done_cyc, last_hs + 1);
        end
        n_vec++;
        if ({overflow, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL overflow_sticky: got ovf=%b busy=%b, required 1 0", overflow, busy);
        end
    endtask

    task automatic test_mid_reset;
        logic        hs, done, ov;
        logic [8:0]  word;
        logic [3:0]  fl;
        logic [15:0] v [16];
        logic [7:0]  e [16];
        start = 1'b1;
        shift_amt = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) stream_cycle(1'b1, 16'(100 + i), 1'b0, hs, word, done, ov, fl);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({out_data, out_last, out_valid, busy, tile_done, overflow, fill_level} !== 17'd0) begin
            n_err++;
            $display("FAIL mid_reset: got data=%h last=%b valid=%b busy=%b done=%b ovf=%b fill=%0d, required all 0",
                     out_data, out_last, out_valid, busy, tile_done, overflow, fill_level);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v[i] = 16'($urandom);
            e[i] = model_rq(v[i], 3);
        end
        test_tile("after_reset", 4'd3, v, e, 0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; shift_amt = 4'd0;
        psum_in = 16'h0000; psum_valid = 1'b0; out_ready = 1'b0;
        n_vec = 0; n_err = 0;
        test_reset;
        test_rounding;
        test_saturation;
        test_negative;
        test_overflow;
        test_full_tile;
        test_back_to_back;
        test_mid_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
